// File: rtl/gmii_demux.sv
`default_nettype none
// ============================================================================
// Module      : gmii_demux
// Description : Receive-side byte-stream demultiplexer. The first byte of
//               each frame selects the destination channel; the frame is
//               steered to that channel through a single shared output
//               register. Frames with an out-of-range index are discarded
//               and counted.
// Ports       : Clk, Rst            - clock, synchronous active-high reset
//               Input_data/valid/last/ready - upstream byte stream
//               Output_data[i]/valid[i]/last[i]/ready[i] - per-channel streams
//               Drop_count          - saturating count of discarded frames
// Revision    : 1.0 - initial release
// ============================================================================
module gmii_demux #(
    parameter int NUM_OUTPUTS  = 2,
    parameter int STRIP_HEADER = 0,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic [7:0]             Input_data,
    input  logic                   Input_valid,
    input  logic                   Input_last,
    output logic                   Input_ready,
    output logic [7:0]             Output_data [NUM_OUTPUTS-1:0],
    output logic [NUM_OUTPUTS-1:0] Output_valid,
    output logic [NUM_OUTPUTS-1:0] Output_last,
    input  logic [NUM_OUTPUTS-1:0] Output_ready,
    output logic [COUNT_WIDTH-1:0] Drop_count
);

    localparam int SEL_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

    localparam logic [1:0] c_S_HEADER  = 2'd0;
    localparam logic [1:0] c_S_FORWARD = 2'd1;
    localparam logic [1:0] c_S_DROP    = 2'd2;

    localparam logic [COUNT_WIDTH-1:0] c_CNT_MAX = '1;

    logic [1:0]             r_state;
    logic                   r_valid;
    logic [7:0]             r_data;
    logic                   r_last;
    logic [SEL_W-1:0]       r_sel;   // channel owning the output register
    logic [SEL_W-1:0]       r_chan;  // channel of the frame being received
    logic [COUNT_WIDTH-1:0] r_drop_count;

    logic                   w_free;
    logic                   w_idx_ok;
    logic                   w_hdr_fwd;
    logic                   w_ready_raw;
    logic                   w_accept;
    logic                   w_load;
    logic                   w_drop;
    logic [SEL_W-1:0]       w_hdr_sel;
    logic [SEL_W-1:0]       w_load_sel;
    logic [1:0]             w_state_nxt;

    always_comb begin
        // The register may take a new byte when empty or when its current
        // owner is draining it this cycle; other channels' ready is ignored.
        w_free    = !r_valid || Output_ready[r_sel];
        w_idx_ok  = ({24'd0, Input_data} < 32'(NUM_OUTPUTS));
        w_hdr_sel = Input_data[SEL_W-1:0];
        // Header goes into the output register only when forwarded.
        w_hdr_fwd = (STRIP_HEADER == 0) && w_idx_ok;

        case (r_state)
            c_S_HEADER:  w_ready_raw = w_hdr_fwd ? w_free : 1'b1;
            c_S_FORWARD: w_ready_raw = w_free;
            default:     w_ready_raw = 1'b1;
        endcase

        Input_ready = !Rst && w_ready_raw;
        w_accept    = Input_valid && Input_ready;

        w_load = w_accept && ((r_state == c_S_FORWARD) ||
                              ((r_state == c_S_HEADER) && w_hdr_fwd));
        w_load_sel = (r_state == c_S_HEADER) ? w_hdr_sel : r_chan;

        // A frame is discarded when its final byte is accepted while dropping,
        // or when a lone header is not forwarded (bad index, or stripped).
        w_drop = w_accept && Input_last &&
                 (((r_state == c_S_HEADER) && !w_hdr_fwd) || (r_state == c_S_DROP));

        w_state_nxt = r_state;
        case (r_state)
            c_S_HEADER: begin
                if (w_accept && !Input_last)
                    w_state_nxt = w_idx_ok ? c_S_FORWARD : c_S_DROP;
            end
            c_S_FORWARD, c_S_DROP: begin
                if (w_accept && Input_last)
                    w_state_nxt = c_S_HEADER;
            end
            default: w_state_nxt = c_S_HEADER;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= c_S_HEADER;
            r_valid      <= 1'b0;
            r_data       <= 8'd0;
            r_last       <= 1'b0;
            r_sel        <= '0;
            r_chan       <= '0;
            r_drop_count <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= Input_data;
                r_last  <= Input_last;
                r_sel   <= w_load_sel;
            end else if (w_free) begin
                r_valid <= 1'b0;
            end

            // Kept apart from r_sel so a stripped header can be taken while
            // the previous frame's last byte still waits in the register.
            if (w_accept && (r_state == c_S_HEADER) && w_idx_ok)
                r_chan <= w_hdr_sel;

            if (w_drop && (r_drop_count != c_CNT_MAX))
                r_drop_count <= r_drop_count + COUNT_WIDTH'(1);
        end
    end

    assign Drop_count = r_drop_count;

    generate
        for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_out
            assign Output_data[i]  = r_data;
            assign Output_valid[i] = r_valid && (r_sel == SEL_W'(i));
            assign Output_last[i]  = r_last && (r_sel == SEL_W'(i));
        end
    endgenerate

endmodule
`default_nettype wire
